// File: rtl/benes_route_cfg_sequencer.sv
// Route-config sequencer for the Benes interconnect: collects per-stage select words
// into a shadow bank and commits them to the active bank once the network has drained.
module benes_route_cfg_sequencer #(
  parameter int unsigned STAGE_NUM    = 9,
  parameter int unsigned SEL_WIDTH    = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CMD_SET_SEL  = 30,
  parameter int unsigned CMD_COMMIT   = 31,
  parameter int unsigned CMD_RESET    = 111
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic [7:0]                     i_command,
  input  logic [31:0]                    i_data0,
  input  logic [31:0]                    i_data1,
  input  logic                           i_net_busy,
  output logic [STAGE_NUM*SEL_WIDTH-1:0] o_module_select,
  output logic [STAGE_NUM*SEL_WIDTH-1:0] o_slot_select,
  output logic                           o_commit_done,
  output logic                           o_err,
  output logic [1:0]                     o_err_code,
  output logic [7:0]                     o_epoch,
  output logic                           o_busy
);

  localparam int unsigned BUS_W  = STAGE_NUM * SEL_WIDTH;
  localparam int unsigned MASK_W = 2 * STAGE_NUM;
  localparam int unsigned CNT_W  = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT} state_t;

  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [BUS_W-1:0]    shadow_mod_q, shadow_slot_q;
  logic [MASK_W-1:0]   mask_q;
  logic                shadow_wr, shadow_clr, commit_en, err_nxt;
  logic [1:0]          err_code_nxt;

  int unsigned         stage_ix;
  logic                side;
  logic [SEL_WIDTH-1:0] sel_word;
  logic                unused_ok;

  assign stage_ix  = 32'(i_data0[3:0]);
  assign side      = i_data0[4];
  assign sel_word  = i_data1[SEL_WIDTH-1:0];
  assign unused_ok = ^{i_data0[31:5], i_data1[31:SEL_WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next-state and command decode; only IDLE accepts commands.
  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    shadow_wr    = 1'b0;
    shadow_clr   = 1'b0;
    commit_en    = 1'b0;
    err_nxt      = 1'b0;
    err_code_nxt = o_err_code;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          if (i_command == 8'(CMD_SET_SEL)) begin
            if (stage_ix < STAGE_NUM) begin
              shadow_wr = 1'b1;
            end else begin
              err_nxt      = 1'b1;
              err_code_nxt = 2'd1;
            end
          end else if (i_command == 8'(CMD_COMMIT)) begin
            if (&mask_q) begin
              state_nxt = S_WAIT;
              cnt_nxt   = '0;
            end else begin
              err_nxt      = 1'b1;
              err_code_nxt = 2'd2;
            end
          end else if (i_command == 8'(CMD_RESET)) begin
            shadow_clr = 1'b1;
          end else begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'd3;
          end
        end
      end
      S_WAIT: begin
        if (i_net_busy) begin
          cnt_nxt = '0;
        end else if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_nxt = S_COMMIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        commit_en = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered status outputs, derived from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cmd_ready   <= 1'b1;
      o_busy        <= 1'b0;
      o_commit_done <= 1'b0;
      o_err         <= 1'b0;
      o_err_code    <= 2'd0;
    end else begin
      o_cmd_ready   <= (state_nxt == S_IDLE);
      o_busy        <= (state_nxt != S_IDLE);
      o_commit_done <= commit_en;
      o_err         <= err_nxt;
      o_err_code    <= err_code_nxt;
    end
  end

  // Shadow bank, written-mask, active bank and epoch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_mod_q    <= '0;
      shadow_slot_q   <= '0;
      mask_q          <= '0;
      o_module_select <= '0;
      o_slot_select   <= '0;
      o_epoch         <= 8'd0;
    end else begin
      if (shadow_clr) begin
        shadow_mod_q  <= '0;
        shadow_slot_q <= '0;
      end else if (shadow_wr) begin
        for (int unsigned s = 0; s < STAGE_NUM; s++) begin
          if (stage_ix == s) begin
            if (side) shadow_slot_q[s*SEL_WIDTH +: SEL_WIDTH] <= sel_word;
            else      shadow_mod_q[s*SEL_WIDTH +: SEL_WIDTH]  <= sel_word;
          end
        end
      end
      if (shadow_clr || commit_en) begin
        mask_q <= '0;
      end else if (shadow_wr) begin
        for (int unsigned s = 0; s < STAGE_NUM; s++) begin
          if (stage_ix == s) begin
            if (side) mask_q[STAGE_NUM + s] <= 1'b1;
            else      mask_q[s]             <= 1'b1;
          end
        end
      end
      if (commit_en) begin
        o_module_select <= shadow_mod_q;
        o_slot_select   <= shadow_slot_q;
        o_epoch         <= o_epoch + 8'd1;
      end
    end
  end

endmodule

// File: doc/benes_route_cfg_sequencer.md
Name: benes_route_cfg_sequencer

Overview:
- Sits directly upstream of the Benes buffer/module interconnect and produces its per-stage switch-select words (module side and slot side, STAGE_NUM words each).
- Takes route words from the host command path (valid/command/data0/data1, FSIZE=32) into a shadow bank.
- Copies the shadow bank into the active bank atomically, and only after the network has drained, so routing never changes while data is in flight.

Parameters:
- STAGE_NUM, 9, Benes stages (2*log2(32)-1).
- SEL_WIDTH, 16, switch-control bits per stage (SWITCH_NUM).
- DRAIN_CYCLES, 4, consecutive cycles i_net_busy must be low before commit.
- CMD_SET_SEL, 30, opcode: write one shadow word.
- CMD_COMMIT, 31, opcode: commit shadow to active.
- CMD_RESET, 111, opcode: clear shadow and written-mask (COMMAND_RESET).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted when valid&&ready.
- i_command  in  8  opcode.
- i_data0  in  32  [3:0] stage index; [4] side (0=module, 1=slot); rest ignored.
- i_data1  in  32  [SEL_WIDTH-1:0] select word; rest ignored.
- i_net_busy  in  1  interconnect has data in flight.
- o_module_select  out  STAGE_NUM*SEL_WIDTH  active module-side words; stage s at bits [s*16+:16].
- o_slot_select  out  STAGE_NUM*SEL_WIDTH  active slot-side words, same packing.
- o_commit_done  out  1  one-cycle pulse when the active bank has been updated.
- o_err  out  1  one-cycle pulse on a rejected command.
- o_err_code  out  2  1=stage out of range, 2=commit with incomplete mask, 3=unknown opcode; holds until the next error.
- o_epoch  out  8  count of commits, wraps 255->0.
- o_busy  out  1  high in WAIT and COMMIT.

Behaviour:
- Reset, async: active banks=0 (straight-through), shadow=0, written-mask=0, epoch=0, err_code=0, o_err=0, o_commit_done=0, state=IDLE, o_cmd_ready=1.
- Written-mask has 2*STAGE_NUM bits: bit = side*STAGE_NUM+stage.

States:
- IDLE: o_cmd_ready=1.
  - SET_SEL with stage<STAGE_NUM: writes the shadow word next edge and sets its mask bit. Rewriting the same word before commit overwrites it; last write wins.
  - SET_SEL with stage>=STAGE_NUM: no write; o_err pulse, code 1.
  - COMMIT with mask all-ones: go to WAIT and clear the drain counter.
  - COMMIT with mask not all-ones: o_err pulse, code 2; stay IDLE; shadow and mask kept.
  - RESET opcode: shadow=0 and mask=0 next edge; active bank, epoch and err_code unchanged.
  - Any other opcode: o_err pulse, code 3.
- WAIT: o_cmd_ready=0, commands stalled.
  - Drain counter increments each cycle i_net_busy=0 and resets to 0 whenever i_net_busy=1.
  - When the counter reaches DRAIN_CYCLES, go to COMMIT.
- COMMIT: o_cmd_ready=0.
  - Active banks <= shadow in a single edge, so all 2*STAGE_NUM words change in the same cycle.
  - mask <= 0; epoch <= epoch+1; the shadow contents are retained.
  - Next state IDLE. o_commit_done is a registered pulse high in the first IDLE cycle, the same cycle the new selects are visible.

Latency and timing rules:
- Minimum COMMIT-accept to o_commit_done with the network idle = DRAIN_CYCLES+2 cycles.
- Outputs are registered; no combinational path from i_* to o_*_select.
- Only one command is accepted per cycle.
- o_err and o_commit_done never assert in the same cycle.
- i_net_busy is ignored outside WAIT.
- rst asserted in WAIT or COMMIT: everything returns to reset values immediately; a partially drained commit is abandoned and no pulse is issued.

Test Plan:
- Reset then no commands -> both select buses=0, o_epoch=0, o_cmd_ready=1.
- Write all 18 words (module stage s = 16'h1000+s, slot stage s = 16'h2000+s), COMMIT with i_net_busy=0 -> o_commit_done 6 cycles after accept; o_module_select[31:16]=16'h1001; o_epoch=1.
- Write only 17 words, COMMIT -> o_err pulse, o_err_code=2, selects unchanged, o_cmd_ready stays 1.
- SET_SEL with stage=9 -> o_err pulse, o_err_code=1, mask unchanged; opcode 77 -> o_err_code=3.
- Full mask, COMMIT, i_net_busy pattern 0,0,1,0,0,0,0 -> commit only after the final 4 low cycles; o_cmd_ready=0 throughout; SET_SEL held valid in WAIT is accepted only after return to IDLE.
- Assert rst 2 cycles into WAIT -> selects=0, epoch=0, no o_commit_done; 256 commits -> o_epoch wraps to 0.
